// File: rtl/cordic_floatingpoint_job_arbiter.sv
// Job arbiter sharing one floating-point CORDIC core between two requester
// FIFOs (A and B). Grants a FIFO read, launches the job into the core, and
// tracks job ownership in a tag FIFO so each result-valid pulse from the
// core is steered back to its requester in launch order.
module cordic_floatingpoint_job_arbiter #(
    parameter int TAG_DEPTH = 4,
    parameter int CNT_W     = $clog2(TAG_DEPTH + 1)
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic [1:0]       iMode,
    input  logic             iFifo_empty_a,
    input  logic             iFifo_empty_b,
    output logic             oFifo_rdreq_a,
    output logic             oFifo_rdreq_b,
    output logic             oSel,
    input  logic             iCore_ready,
    output logic             oIssue,
    input  logic             iCore_valid,
    output logic             oValid_a,
    output logic             oValid_b,
    output logic [CNT_W-1:0] oOutstanding,
    output logic             oBusy,
    output logic             oError
);

    localparam int               PTR_W   = $clog2(TAG_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TAG_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        LAUNCH
    } state_t;

    state_t           state_q;
    logic             last_grant_q;   // 0 = A, 1 = B
    logic             sel_q;
    logic             rdreq_a_q;
    logic             rdreq_b_q;
    logic             issue_q;
    logic             valid_a_q;
    logic             valid_b_q;
    logic             error_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             tags_q [TAG_DEPTH];

    logic             any_req;
    logic             grant;
    logic             win_d;
    logic             push;
    logic             pop;

    // Pick the winning requester and decide whether a grant happens this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        win_d = ~last_grant_q;
        if (iFifo_empty_a) begin
            win_d = 1'b1;
        end else if (iFifo_empty_b) begin
            win_d = 1'b0;
        end else begin
            case (iMode)
                2'd1:    win_d = 1'b0;
                2'd2:    win_d = 1'b1;
                default: win_d = ~last_grant_q;
            endcase
        end
    end

    assign any_req = ~iFifo_empty_a | ~iFifo_empty_b;
    assign grant   = (state_q == IDLE) & iCore_ready & (count_q < DEPTH_C) & any_req;
    // The winner is held on sel_q through LAUNCH, so it doubles as the tag.
    assign push    = (state_q == LAUNCH);
    // A result with no job in flight is an error, not a pop.
    assign pop     = iCore_valid & (count_q != '0);

    // Grant / read / launch sequencer with registered one-cycle pulses.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            sel_q        <= 1'b0;
            rdreq_a_q    <= 1'b0;
            rdreq_b_q    <= 1'b0;
            issue_q      <= 1'b0;
        end else begin
            // NOTE: pulses default low each cycle and are raised only in the branch that owns them.
            rdreq_a_q <= 1'b0;
            rdreq_b_q <= 1'b0;
            issue_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        rdreq_a_q    <= ~win_d;
                        rdreq_b_q    <= win_d;
                        sel_q        <= win_d;
                        last_grant_q <= win_d;
                        state_q      <= READ;
                    end
                end
                READ: begin
                    issue_q <= 1'b1;
                    state_q <= LAUNCH;
                end
                LAUNCH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Tag FIFO pointers, outstanding counter, result steering and sticky error.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            valid_a_q <= pop & ~tags_q[rd_ptr_q];
            valid_b_q <= pop & tags_q[rd_ptr_q];
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (iCore_valid && (count_q == '0)) begin
                error_q <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Tag storage written at launch with the owning requester.
    always_ff @(posedge iClk) begin
        // NOTE: storage has no reset; resetting the pointers and count is what flushes it.
        if (push) begin
            tags_q[wr_ptr_q] <= sel_q;
        end
    end

    assign oFifo_rdreq_a = rdreq_a_q;
    assign oFifo_rdreq_b = rdreq_b_q;
    assign oSel          = sel_q;
    assign oIssue        = issue_q;
    assign oValid_a      = valid_a_q;
    assign oValid_b      = valid_b_q;
    assign oOutstanding  = count_q;
    assign oBusy         = (state_q != IDLE) | (count_q != '0);
    assign oError        = error_q;

endmodule

// File: doc/cordic_floatingpoint_job_arbiter.md
# cordic_floatingpoint_job_arbiter

Shares one floating-point CORDIC core between two requester input FIFOs (A and B). The block arbitrates between the FIFOs and issues FIFO reads. It launches each job into the core's control logic and records which requester owns each in-flight job. It then routes the core's result-valid pulse back to the owning requester, in launch order. It sits between the two input FIFOs and the core's control/datapath, and drives the operand mux select.

## Interface
- TAG_DEPTH, 4, maximum number of outstanding jobs; power of two, ≥2
- CNT_W, $clog2(TAG_DEPTH+1), width of the outstanding-job counter
- iClk  in  1  clock; all logic on the rising edge
- iReset  in  1  reset, synchronous, active-high
- iMode  in  2  arbitration mode: 0 = round-robin, 1 = fixed priority A, 2 = fixed priority B, 3 = treated as 0
- iFifo_empty_a  in  1  FIFO A empty flag
- iFifo_empty_b  in  1  FIFO B empty flag
- oFifo_rdreq_a  out  1  read request to FIFO A, one-cycle pulse
- oFifo_rdreq_b  out  1  read request to FIFO B, one-cycle pulse
- oSel  out  1  operand mux select: 0 = A, 1 = B; held until the next grant
- iCore_ready  in  1  core can accept a new job
- oIssue  out  1  job launch pulse to the core
- iCore_valid  in  1  core result-valid pulse, one per job, in launch order
- oValid_a  out  1  result belongs to A
- oValid_b  out  1  result belongs to B
- oOutstanding  out  CNT_W  jobs launched and not yet returned
- oBusy  out  1  FSM not in IDLE, or oOutstanding ≠ 0
- oError  out  1  sticky: iCore_valid arrived with no outstanding job

## Operation
FSM states: IDLE, READ, LAUNCH.

- **IDLE:** a grant occurs when iCore_ready=1, oOutstanding<TAG_DEPTH, and at least one FIFO is non-empty.
  - The winner's rdreq is asserted for one cycle and oSel is set to the winner.
  - Next state is READ; otherwise the FSM stays in IDLE.
- **READ:** FIFO data arrives this cycle. Next state is LAUNCH unconditionally.
- **LAUNCH:** oIssue=1 for one cycle.
  - The winner's tag (0=A, 1=B) is pushed into the tag FIFO (TAG_DEPTH entries).
  - Next state is IDLE.
- Issue rate is at most one job per 3 cycles. rdreq is never asserted for a FIFO whose empty flag is 1 in the grant cycle.

Arbitration:
- Only one FIFO non-empty: that FIFO wins, in every mode.
- Both non-empty, mode 1: A wins. Mode 2: B wins.
- Both non-empty, mode 0/3: the FIFO not granted last wins. The last-grant register resets to B, so A wins first.
- The last-grant register updates on every grant, in all modes.

Return path:
- On iCore_valid, the head tag is popped and oValid_a or oValid_b pulses for one cycle (registered).
- iCore_valid with the tag FIFO empty: no oValid pulse, no pop, oError set until reset.

Counter:
- oOutstanding increments on push and decrements on pop.
- Push and pop in the same cycle leaves it unchanged; the tag FIFO write and read are both performed, and the pointers wrap modulo TAG_DEPTH.
- Push when full cannot occur, because the grant is blocked when oOutstanding=TAG_DEPTH.

iCore_ready falling while in READ or LAUNCH does not abort the job; the launch completes.

Reset (any state, including mid-job):
- FSM goes to IDLE and the tag FIFO and pointers are flushed.
- All outputs go to 0: rdreq, oSel, oIssue, oValid, oOutstanding, oBusy, oError.
- Last-grant resets to B.
- The core must be reset in the same cycle. A result returned after reset sets oError.

## Timing
- Grant cycle T (IDLE, conditions met): rdreq registered, high during T+1.
- READ during T+1; oIssue high during T+2; oOutstanding increments visible at T+3.
- iCore_valid in cycle C → oValid_x high in C+1 and oOutstanding decrement visible in C+1.
- oSel changes only on the edge that raises rdreq. It is stable from READ through the following IDLE.
- Earliest next grant: IDLE evaluation in T+3.
- oError rises the cycle after the offending iCore_valid.

## Test plan
1. **Reset values:** hold iReset=1 for 3 cycles with both FIFOs non-empty → all outputs 0, no rdreq. Release reset → A granted first (rdreq_a then oIssue two cycles later, oSel=0).
2. **Round-robin, iMode=0, both non-empty, iCore_ready=1, core returns each job 5 cycles after oIssue:**
   - Grants are A,B,A,B…, with oIssue every 3 cycles.
   - oValid follows in the same order.
   - oOutstanding never exceeds 2.
3. **Back-pressure, TAG_DEPTH=4, core never returns:**
   - Exactly 4 oIssue pulses, then oOutstanding=4 and no further rdreq.
   - One iCore_valid → oValid for the first tag, oOutstanding=3, one new grant.
4. **Fixed priority and empty handling:**
   - iMode=2, both non-empty → only B granted.
   - B empties → A granted.
   - Both empty → FSM stays in IDLE, oBusy=0 once oOutstanding=0.
5. **Simultaneous push/pop:** iCore_valid in the LAUNCH cycle with oOutstanding=1 → oOutstanding stays 1, the oValid tag matches the older job, and the tag FIFO wrap is verified over 10 jobs.
6. **Error and mid-job reset:**
   - iCore_valid with oOutstanding=0 → oError=1 next cycle, no oValid.
   - iReset asserted during READ → no oIssue, all outputs 0 next cycle.
